adder_arbiter: RTL and testbench

ADDER_ARBITER -- requirements
Module: adder_arbiter

---
 rtl/adder_arbiter.sv | 129 ++++++++++++
 tb/tb_adder_arbiter.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/adder_arbiter.sv
// adder_arbiter: NREQ requesters share one W-bit adder through round-robin arbitration.
// A granted request is summed on the accepting edge and the result is held until
// its owner accepts it; the block then returns to accepting new requests.
//
// Ports:
//   clk        - clock, all state updates on the rising edge
//   rst_n      - synchronous active-low reset
//   req_valid  - [NREQ]   per-requester operation request
//   req_a      - [NREQ*W] operand A, requester i at [i*W +: W]
//   req_b      - [NREQ*W] operand B, same packing
//   req_ready  - [NREQ]   one-hot request accept (combinational)
//   res_valid  - [NREQ]   one-hot result valid at the owner
//   res_ready  - [NREQ]   per-requester result accept (only the owner's bit matters)
//   res_data   - [W]      registered sum
//   res_cout   - registered carry-out of the sum
module adder_arbiter #(
    parameter int unsigned NREQ = 3,
    parameter int unsigned W    = 32
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [NREQ-1:0]     req_valid,
    input  logic [NREQ*W-1:0]   req_a,
    input  logic [NREQ*W-1:0]   req_b,
    output logic [NREQ-1:0]     req_ready,
    output logic [NREQ-1:0]     res_valid,
    input  logic [NREQ-1:0]     res_ready,
    output logic [W-1:0]        res_data,
    output logic                res_cout
);

    localparam int unsigned PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic {
        IDLE = 1'b0,
        RESP = 1'b1
    } state_t;

    state_t          state_q, state_d;
    logic [PW-1:0]   ptr_q, ptr_d;
    logic [PW-1:0]   owner_q, owner_d;
    logic [W-1:0]    res_data_q, res_data_d;
    logic            res_cout_q, res_cout_d;
    logic [NREQ-1:0] res_valid_q, res_valid_d;

    logic            any_valid;
    logic [PW-1:0]   sel;
    logic [W-1:0]    a_sel;
    logic [W-1:0]    b_sel;
    logic [W:0]      sum;

    // Round-robin pick: first asserted request searching upward from ptr+1 with wrap.
    always_comb begin
        any_valid = 1'b0;
        sel       = '0;
        for (int unsigned k = 1; k <= NREQ; k++) begin
            if (!any_valid && req_valid[(32'(ptr_q) + k) % NREQ]) begin
                any_valid = 1'b1;
                sel       = PW'((32'(ptr_q) + k) % NREQ);
            end
        end
    end

    // Operand mux and full-width add of the selected requester.
    always_comb begin
        a_sel = req_a[32'(sel)*W +: W];
        b_sel = req_b[32'(sel)*W +: W];
        sum   = (W+1)'(a_sel) + (W+1)'(b_sel);
    end

    // Next-state and handshake logic.
    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        owner_d     = owner_q;
        res_data_d  = res_data_q;
        res_cout_d  = res_cout_q;
        res_valid_d = res_valid_q;
        req_ready   = '0;

        case (state_q)
            IDLE: begin
                // rst_n gating keeps req_ready low while reset is held.
                if (any_valid && rst_n) begin
                    req_ready   = NREQ'(1) << sel;
                    state_d     = RESP;
                    owner_d     = sel;
                    res_data_d  = sum[W-1:0];
                    res_cout_d  = sum[W];
                    res_valid_d = NREQ'(1) << sel;
                end
            end
            RESP: begin
                if (res_ready[owner_q]) begin
                    state_d     = IDLE;
                    ptr_d       = owner_q;
                    res_valid_d = '0;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and result registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            ptr_q       <= PW'(NREQ - 1);
            owner_q     <= '0;
            res_data_q  <= '0;
            res_cout_q  <= 1'b0;
            res_valid_q <= '0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            owner_q     <= owner_d;
            res_data_q  <= res_data_d;
            res_cout_q  <= res_cout_d;
            res_valid_q <= res_valid_d;
        end
    end

    assign res_valid = res_valid_q;
    assign res_data  = res_data_q;
    assign res_cout  = res_cout_q;

endmodule

// File: tb/tb_adder_arbiter.sv
// Directed testbench for adder_arbiter (NREQ=3, W=32).
module tb_adder_arbiter;

    localparam int unsigned NREQ = 3;
    localparam int unsigned W    = 32;

    logic              clk;
    logic              rst_n;
    logic [NREQ-1:0]   req_valid;
    logic [NREQ*W-1:0] req_a;
    logic [NREQ*W-1:0] req_b;
    logic [NREQ-1:0]   req_ready;
    logic [NREQ-1:0]   res_valid;
    logic [NREQ-1:0]   res_ready;
    logic [W-1:0]      res_data;
    logic              res_cout;

    int n_checks;
    int n_errors;

    logic [W-1:0] exp_sum  [NREQ];
    logic         exp_cout [NREQ];

    adder_arbiter #(.NREQ(NREQ), .W(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_ready (req_ready),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_data  (res_data),
        .res_cout  (res_cout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_op(input int i, input logic [W-1:0] a, input logic [W-1:0] b);
        req_a[i*W +: W] = a;
        req_b[i*W +: W] = b;
    endtask

    initial begin
        n_checks  = 0;
        n_errors  = 0;
        rst_n     = 1'b0;
        req_valid = '0;
        req_a     = '0;
        req_b     = '0;
        res_ready = '0;

        // Reset: ready must stay low even with requests present.
        tick();
        req_valid = 3'b111;
        #1;
        check_eq("rst_req_ready", 64'(req_ready), 64'(3'b000));
        tick();
        check_eq("rst_res_valid", 64'(res_valid), 64'(3'b000));
        check_eq("rst_res_data",  64'(res_data),  64'd0);
        check_eq("rst_res_cout",  64'(res_cout),  64'd0);
        req_valid = '0;

        // Simple add on requester 0: 5 + 7.
        rst_n     = 1'b1;
        set_op(0, 32'd5, 32'd7);
        req_valid = 3'b001;
        #1;
        check_eq("add0_req_ready", 64'(req_ready), 64'(3'b001));
        tick();
        req_valid = '0;
        #1;
        check_eq("add0_res_valid", 64'(res_valid), 64'(3'b001));
        check_eq("add0_res_data",  64'(res_data),  64'd12);
        check_eq("add0_res_cout",  64'(res_cout),  64'd0);
        check_eq("add0_ready_resp", 64'(req_ready), 64'(3'b000));
        res_ready = 3'b001;
        tick();
        res_ready = '0;
        #1;
        check_eq("add0_done", 64'(res_valid), 64'(3'b000));

        // No request in IDLE: everything holds.
        tick();
        check_eq("idle_hold_valid", 64'(res_valid), 64'(3'b000));
        check_eq("idle_hold_data",  64'(res_data),  64'd12);

        // Carry-out wrap on requester 1.
        set_op(1, 32'hFFFF_FFFF, 32'd1);
        req_valid = 3'b010;
        #1;
        check_eq("wrap_req_ready", 64'(req_ready), 64'(3'b010));
        tick();
        req_valid = '0;
        #1;
        check_eq("wrap_res_valid", 64'(res_valid), 64'(3'b010));
        check_eq("wrap_res_data",  64'(res_data),  64'h0);
        check_eq("wrap_res_cout",  64'(res_cout),  64'd1);
        res_ready = 3'b111;
        tick();
        res_ready = '0;

        // Round-robin from reset: grants 0,1,2,0,1,2.
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        set_op(0, 32'h0000_0010, 32'h0000_0020);
        set_op(1, 32'h8000_0000, 32'h8000_0001);
        set_op(2, 32'h1234_5678, 32'h1111_1111);
        exp_sum[0] = 32'h0000_0030; exp_cout[0] = 1'b0;
        exp_sum[1] = 32'h0000_0001; exp_cout[1] = 1'b1;
        exp_sum[2] = 32'h2345_6789; exp_cout[2] = 1'b0;
        req_valid = 3'b111;
        res_ready = 3'b111;
        for (int n = 0; n < 6; n++) begin
            int unsigned g;
            g = n % 3;
            #1;
            check_eq($sformatf("rr%0d_req_ready", n), 64'(req_ready), 64'(3'b001 << g));
            tick();
            check_eq($sformatf("rr%0d_res_valid", n), 64'(res_valid), 64'(3'b001 << g));
            check_eq($sformatf("rr%0d_res_data", n),  64'(res_data),  64'(exp_sum[g]));
            check_eq($sformatf("rr%0d_res_cout", n),  64'(res_cout),  64'(exp_cout[g]));
            check_eq($sformatf("rr%0d_ready_resp", n), 64'(req_ready), 64'(3'b000));
            tick();
        end
        res_ready = '0;
        req_valid = '0;

        // Backpressure: result and ready stable while operands change (ptr=2, so 0 wins).
        set_op(0, 32'd3, 32'd4);
        req_valid = 3'b001;
        #1;
        check_eq("bp_req_ready", 64'(req_ready), 64'(3'b001));
        tick();
        req_valid = 3'b111;
        for (int n = 0; n < 5; n++) begin
            set_op(0, 32'(n * 1000 + 11), 32'(n * 77 + 5));
            set_op(1, 32'(n + 1), 32'(n + 2));
            #1;
            check_eq($sformatf("bp%0d_res_valid", n), 64'(res_valid), 64'(3'b001));
            check_eq($sformatf("bp%0d_res_data", n),  64'(res_data),  64'd7);
            check_eq($sformatf("bp%0d_req_ready", n), 64'(req_ready), 64'(3'b000));
            tick();
        end
        req_valid = '0;
        res_ready = 3'b001;
        tick();
        res_ready = '0;

        // Owner 2; non-owner res_ready bits are ignored.
        set_op(2, 32'd10, 32'd20);
        req_valid = 3'b100;
        #1;
        check_eq("own2_req_ready", 64'(req_ready), 64'(3'b100));
        tick();
        req_valid = '0;
        res_ready = 3'b011;
        tick();
        check_eq("own2_hold1_valid", 64'(res_valid), 64'(3'b100));
        tick();
        check_eq("own2_hold2_valid", 64'(res_valid), 64'(3'b100));
        check_eq("own2_hold2_data",  64'(res_data),  64'd30);
        res_ready = 3'b100;
        tick();
        res_ready = '0;
        set_op(0, 32'd1, 32'd2);
        req_valid = 3'b111;
        #1;
        check_eq("own2_done_valid", 64'(res_valid), 64'(3'b000));
        check_eq("own2_next_prefers0", 64'(req_ready), 64'(3'b001));

        // Reset while holding a result discards it.
        tick();
        check_eq("rstresp_pre_valid", 64'(res_valid), 64'(3'b001));
        check_eq("rstresp_pre_data",  64'(res_data),  64'd3);
        rst_n = 1'b0;
        #1;
        check_eq("rstresp_ready_low", 64'(req_ready), 64'(3'b000));
        tick();
        rst_n = 1'b1;
        #1;
        check_eq("rstresp_res_valid", 64'(res_valid), 64'(3'b000));
        check_eq("rstresp_res_data",  64'(res_data),  64'd0);
        check_eq("rstresp_req_ready", 64'(req_ready), 64'(3'b001));

        // Request withdrawn before a clock edge causes no operation.
        req_valid = '0;
        tick();
        check_eq("withdraw_valid", 64'(res_valid), 64'(3'b000));
        check_eq("withdraw_data",  64'(res_data),  64'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
